acc_frame_stats: RTL
====================

# acc_frame_stats

Frame-statistics stage directly downstream of the accumulator. Consumes the accumulator's `o_data`/`o_overflow` sample stream, saturates overflowed samples, and groups samples into fixed-length frames. Per frame it reports the sum, the peak and the overflow count through a 2-entry output buffer with a valid/ready handshake. Frames that cannot be buffered are dropped, and a sticky drop flag is raised.

## Interface

- `NB_DATA`, 6: width of the accumulator result consumed on `i_data`.
- `LOG2_FRAME`, 2: log2 of frame length; FRAME_LEN = 2^LOG2_FRAME samples.

- `clk` input 1: single clock; all state updates on its rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_valid` input 1: sample qualifier; `i_data`/`i_overflow` are taken on any edge where `i_valid`=1. There is no upstream backpressure.
- `i_data` input NB_DATA: accumulator result, unsigned.
- `i_overflow` input 1: accumulator overflow flag for this sample.
- `i_ready` input 1: downstream is ready to accept the head result.
- `o_valid` output 1: head result is present.
- `o_sum` output NB_DATA+LOG2_FRAME: sum of the frame's saturated samples.
- `o_peak` output NB_DATA: maximum saturated sample in the frame.
- `o_ovf_cnt` output LOG2_FRAME+1: number of samples in the frame with `i_overflow`=1.
- `o_drop` output 1: sticky; set when any frame result has been discarded.

## Operation

- **Saturation:** sample value = `i_overflow` ? all ones (2^NB_DATA−1) : `i_data`.
- **Frame state:**
  - Sample counter `cnt` runs 0..FRAME_LEN−1.
  - Running sum, running peak and overflow count, with widths as the matching outputs.
  - No wrap is possible: the sum fits by construction.
- **Accepted sample, `cnt` < FRAME_LEN−1:**
  - sum += value.
  - peak = max(peak, value).
  - ovf += `i_overflow`.
  - `cnt`++.
- **Accepted sample, `cnt` = FRAME_LEN−1 (frame complete):**
  - The final result includes this sample.
  - The result is pushed to the output buffer.
  - Running state clears to 0, and `cnt` returns to 0.
- **`i_valid`=0:** all frame state holds; gaps of any length are allowed.
- **Output buffer:** 2-entry FIFO of {sum, peak, ovf_cnt}.
  - `o_valid` = buffer non-empty.
  - Outputs show the head entry.
  - Pop occurs when `o_valid`&`i_ready`.
  - Outputs are 0 when the buffer is empty.
- **Push while the buffer is full:**
  - With a pop on the same edge, the push succeeds: the count stays 2 and order is preserved.
  - Without a pop, the new result is discarded and `o_drop` is set. It stays set until `i_rst`.
- **Push and pop on the same edge** with 1 entry: the count stays 1, and the new result becomes head.
- **Reset** has priority over everything. It empties the buffer, clears all frame state and `cnt`, and clears `o_drop`. A partial frame in progress is discarded.

## Timing

- Reset values: `o_valid`=0, `o_sum`=0, `o_peak`=0, `o_ovf_cnt`=0, `o_drop`=0, taking effect from the edge where `i_rst`=1.
- Latency: the last sample of a frame is taken at edge N. The result appears on the outputs with `o_valid`=1 in the cycle after edge N, provided the buffer had a free slot or the head was popped at edge N.
- Throughput: one sample per cycle. With `i_ready` held at 1, one result is output per FRAME_LEN cycles and no drops occur.
- Handshake:
  - `o_valid` does not depend combinationally on `i_ready`.
  - While `o_valid`=1 and `i_ready`=0, the head outputs are stable.
- `o_drop` rises in the cycle after the discarding edge.
- All outputs are registered, or are a mux of registered state only.

## Test plan

- **Reset:** hold `i_rst`=1 for 2 cycles with `i_valid`=1 and random data → all outputs 0 and no result emitted. After release, the first frame counts only post-reset samples.
- **Basic frame:** `i_ready`=1, samples 1,2,3,4 with no overflow → one cycle of `o_valid`=1 after the 4th edge, carrying `o_sum`=10, `o_peak`=4, `o_ovf_cnt`=0.
- **Saturation:** samples 5, (data 0 with `i_overflow`=1), 7, 2, with `i_valid` gaps between them → `o_sum`=77, `o_peak`=63, `o_ovf_cnt`=1.
- **Drop:** `i_ready`=0, three frames of all-1 samples → after frame 2, `o_valid`=1 with head `o_sum`=4. Frame 3 is dropped and `o_drop`=1. Then `i_ready`=1 → exactly 2 results drain, `o_valid` returns to 0, and `o_drop` stays 1.
- **Full with simultaneous pop:** buffer holds 2 entries; `i_ready`=1 exactly on the frame-3 completion edge → no drop, and frame-3 results (all samples 2: `o_sum`=8, `o_peak`=2) follow frame 2 in order.
- **Reset mid-frame:** 2 samples of 9, then `i_rst` for one cycle, then 4 samples of 3 → single result `o_sum`=12, `o_peak`=3, `o_ovf_cnt`=0.

Source files
------------

// File: rtl/acc_frame_stats_if.sv
// Sample-in / frame-result-out bundle for acc_frame_stats.
// The slave modport is the stats block; the master modport drives samples and accepts results.
interface acc_frame_stats_if #(
    parameter int unsigned NB_DATA    = 6,
    parameter int unsigned LOG2_FRAME = 2
) ();

    logic                          i_valid;
    logic [NB_DATA-1:0]            i_data;
    logic                          i_overflow;
    logic                          i_ready;
    logic                          o_valid;
    logic [NB_DATA+LOG2_FRAME-1:0] o_sum;
    logic [NB_DATA-1:0]            o_peak;
    logic [LOG2_FRAME:0]           o_ovf_cnt;
    logic                          o_drop;

    modport slave (
        input  i_valid, i_data, i_overflow, i_ready,
        output o_valid, o_sum, o_peak, o_ovf_cnt, o_drop
    );

    modport master (
        output i_valid, i_data, i_overflow, i_ready,
        input  o_valid, o_sum, o_peak, o_ovf_cnt, o_drop
    );

endinterface

// File: rtl/acc_frame_stats.sv
// Frame statistics over the accumulator sample stream: saturates overflowed samples,
// accumulates sum / peak / overflow count per fixed-length frame and queues results
// in a 2-entry buffer. Results that find the buffer full (and no pop) are dropped.
module acc_frame_stats #(
    parameter int unsigned NB_DATA    = 6,
    parameter int unsigned LOG2_FRAME = 2
) (
    input logic              clk,
    input logic              i_rst,
    acc_frame_stats_if.slave bus
);

    localparam int unsigned NB_SUM = NB_DATA + LOG2_FRAME;
    localparam int unsigned NB_OVF = LOG2_FRAME + 1;
    localparam logic [LOG2_FRAME-1:0] CntLast = '1;

    typedef struct packed {
        logic [NB_SUM-1:0]  sum;
        logic [NB_DATA-1:0] peak;
        logic [NB_OVF-1:0]  ovf;
    } result_t;

    logic [NB_DATA-1:0]    sample;
    logic                  frame_done;
    result_t               frame_res;

    logic [LOG2_FRAME-1:0] cnt_q, cnt_d;
    logic [NB_SUM-1:0]     sum_q, sum_d;
    logic [NB_DATA-1:0]    peak_q, peak_d;
    logic [NB_OVF-1:0]     ovf_q, ovf_d;

    result_t               head_q, head_d;
    result_t               tail_q, tail_d;
    logic [1:0]            count_q, count_d;
    logic                  drop_q, drop_d;
    logic                  push, pop;

    assign sample = bus.i_overflow ? {NB_DATA{1'b1}} : bus.i_data;

    // Running frame statistics including the current sample; cleared after the last one.
    always_comb begin
        frame_res.sum  = sum_q + NB_SUM'(sample);
        frame_res.peak = (sample > peak_q) ? sample : peak_q;
        frame_res.ovf  = ovf_q + NB_OVF'(bus.i_overflow);
        frame_done     = bus.i_valid && (cnt_q == CntLast);

        cnt_d  = cnt_q;
        sum_d  = sum_q;
        peak_d = peak_q;
        ovf_d  = ovf_q;
        if (frame_done) begin
            cnt_d  = '0;
            sum_d  = '0;
            peak_d = '0;
            ovf_d  = '0;
        end else if (bus.i_valid) begin
            cnt_d  = cnt_q + LOG2_FRAME'(1);
            sum_d  = frame_res.sum;
            peak_d = frame_res.peak;
            ovf_d  = frame_res.ovf;
        end
    end

    // Two-entry result buffer; head is what the outputs show, tail is the second slot.
    always_comb begin
        push    = frame_done;
        pop     = (count_q != 2'd0) && bus.i_ready;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        drop_d  = drop_q;

        unique case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = frame_res;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = frame_res;
                end else if (push) begin
                    tail_d  = frame_res;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (push && pop) begin
                    head_d = tail_q;
                    tail_d = frame_res;
                end else if (push) begin
                    // No room and nobody draining: this frame is lost.
                    drop_d = 1'b1;
                end else if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: begin
                count_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset; a partial frame is discarded on reset.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            sum_q   <= '0;
            peak_q  <= '0;
            ovf_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            peak_q  <= peak_d;
            ovf_q   <= ovf_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Outputs are a mux of registered state; zero whenever the buffer is empty.
    assign bus.o_valid   = (count_q != 2'd0);
    assign bus.o_sum     = bus.o_valid ? head_q.sum  : '0;
    assign bus.o_peak    = bus.o_valid ? head_q.peak : '0;
    assign bus.o_ovf_cnt = bus.o_valid ? head_q.ovf  : '0;
    assign bus.o_drop    = drop_q;

endmodule
